// File: rtl/bus_arbiter.sv
// Two-master / two-slave shared-bus controller: grant FSM, owner-driven bus mux,
// address window decode and a registered read-data return path.
module bus_arbiter #(
    parameter logic [7:0] S0_BASE = 8'h00,
    parameter logic [7:0] S0_SIZE = 8'h20,
    parameter logic [7:0] S1_BASE = 8'h20,
    parameter logic [7:0] S1_SIZE = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        M0_req,
    input  logic        M0_wr,
    input  logic [7:0]  M0_address,
    input  logic [31:0] M0_dout,
    input  logic        M1_req,
    input  logic        M1_wr,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M1_dout,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout,
    output logic        M0_grant,
    output logic        M1_grant,
    output logic [31:0] M_din,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic [7:0]  S_address,
    output logic        S_wr,
    output logic [31:0] S_din
);

    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [1:0]  sel_q;
    logic [1:0]  sel_d;
    logic        owner_req;
    logic        owner_wr;
    logic [7:0]  s0_offset;
    logic [7:0]  s1_offset;
    logic        s0_hit;
    logic        s1_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= M0_GRANT;
        end else begin
            state_q <= state_d;
        end
    end

    // M0 is the default owner and wins ties; M1 is never preempted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            M0_GRANT: if (!M0_req && M1_req) state_d = M1_GRANT;
            M1_GRANT: if (!M1_req)           state_d = M0_GRANT;
            default:                         state_d = M0_GRANT;
        endcase
    end

    always_comb begin
        M0_grant = (state_q == M0_GRANT);
        M1_grant = (state_q == M1_GRANT);
    end

    always_comb begin
        if (state_q == M1_GRANT) begin
            owner_req = M1_req;
            owner_wr  = M1_wr;
            S_address = M1_address;
            S_din     = M1_dout;
        end else begin
            owner_req = M0_req;
            owner_wr  = M0_wr;
            S_address = M0_address;
            S_din     = M0_dout;
        end
        S_wr = owner_req & owner_wr;
    end

    // Offset compare handles windows that wrap past 8'hFF; S0 wins any overlap.
    always_comb begin
        s0_offset = S_address - S0_BASE;
        s1_offset = S_address - S1_BASE;
        s0_hit    = (s0_offset < S0_SIZE);
        s1_hit    = (s1_offset < S1_SIZE);
        S0_sel    = owner_req & s0_hit;
        S1_sel    = owner_req & s1_hit & ~s0_hit;
        sel_d     = {S1_sel, S0_sel};
    end

    // Select is delayed one cycle so it lines up with synchronous-read slave data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q <= 2'b00;
        end else begin
            sel_q <= sel_d;
        end
    end

    always_comb begin
        if (sel_q[0]) begin
            M_din = S0_dout;
        end else if (sel_q[1]) begin
            M_din = S1_dout;
        end else begin
            M_din = 32'h0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues timed expectations, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_bus_arbiter;

    localparam int SIG_G0   = 0;
    localparam int SIG_G1   = 1;
    localparam int SIG_DIN  = 2;
    localparam int SIG_SEL0 = 3;
    localparam int SIG_SEL1 = 4;
    localparam int SIG_ADDR = 5;
    localparam int SIG_WR   = 6;
    localparam int SIG_SDIN = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        M0_req, M0_wr, M1_req, M1_wr;
    logic [7:0]  M0_address, M1_address;
    logic [31:0] M0_dout, M1_dout, S0_dout, S1_dout;
    logic        M0_grant, M1_grant, S0_sel, S1_sel, S_wr;
    logic [31:0] M_din, S_din;
    logic [7:0]  S_address;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    exp_t exp_q[$];

    bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .M0_req(M0_req), .M0_wr(M0_wr), .M0_address(M0_address), .M0_dout(M0_dout),
        .M1_req(M1_req), .M1_wr(M1_wr), .M1_address(M1_address), .M1_dout(M1_dout),
        .S0_dout(S0_dout), .S1_dout(S1_dout),
        .M0_grant(M0_grant), .M1_grant(M1_grant), .M_din(M_din),
        .S0_sel(S0_sel), .S1_sel(S1_sel), .S_address(S_address),
        .S_wr(S_wr), .S_din(S_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int sig, input logic [31:0] val);
        exp_t e;
        e.cyc = c;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_G0:   return "M0_grant";
            SIG_G1:   return "M1_grant";
            SIG_DIN:  return "M_din";
            SIG_SEL0: return "S0_sel";
            SIG_SEL1: return "S1_sel";
            SIG_ADDR: return "S_address";
            SIG_WR:   return "S_wr";
            default:  return "S_din";
        endcase
    endfunction

    function automatic logic [31:0] sig_val(input int sig);
        case (sig)
            SIG_G0:   return {31'd0, M0_grant};
            SIG_G1:   return {31'd0, M1_grant};
            SIG_DIN:  return M_din;
            SIG_SEL0: return {31'd0, S0_sel};
            SIG_SEL1: return {31'd0, S1_sel};
            SIG_ADDR: return {24'd0, S_address};
            SIG_WR:   return {31'd0, S_wr};
            default:  return S_din;
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            act = sig_val(e.sig);
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s cycle %0d: expectation missed (now cycle %0d)", sig_name(e.sig), e.cyc, cyc);
            end else if (act !== e.val) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", sig_name(e.sig), cyc, act, e.val);
            end else begin
                $display("ok   %s cycle %0d: %h", sig_name(e.sig), cyc, act);
            end
        end
    end

    task automatic exp_bus(input logic s0, input logic s1, input logic wr,
                           input logic [7:0] a, input logic [31:0] d);
        expect_at(cyc, SIG_SEL0, {31'd0, s0});
        expect_at(cyc, SIG_SEL1, {31'd0, s1});
        expect_at(cyc, SIG_WR,   {31'd0, wr});
        expect_at(cyc, SIG_ADDR, {24'd0, a});
        expect_at(cyc, SIG_SDIN, d);
    endtask

    task automatic exp_grant(input logic g0);
        expect_at(cyc, SIG_G0, {31'd0, g0});
        expect_at(cyc, SIG_G1, {31'd0, ~g0});
    endtask

    // M1 read at the given address: select checked now, data checked next cycle.
    task automatic m1_read(input logic [7:0] a, input logic s0, input logic s1,
                           input logic [31:0] data);
        step();
        M1_address = a;
        exp_grant(1'b0);
        exp_bus(s0, s1, 1'b0, a, 32'h0);
        expect_at(cyc + 1, SIG_DIN, data);
    endtask

    initial begin
        reset_n = 1'b0;
        M0_req = 0; M0_wr = 0; M0_address = 8'h00; M0_dout = 32'h0;
        M1_req = 1; M1_wr = 0; M1_address = 8'h00; M1_dout = 32'h0;
        S0_dout = 32'h22; S1_dout = 32'h11;

        // Reset holds M0 ownership despite M1_req.
        step();
        exp_grant(1'b1);
        expect_at(cyc, SIG_DIN, 32'h0);
        exp_bus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        step();
        reset_n = 1'b1;
        exp_grant(1'b1);
        step();
        exp_grant(1'b0);
        step();
        M1_req = 0;
        exp_grant(1'b0);
        step();
        exp_grant(1'b1);

        // Tie from reset: M0 keeps the bus until it lets go.
        step();
        reset_n = 1'b0; M0_req = 1; M1_req = 1;
        exp_grant(1'b1);
        step();
        reset_n = 1'b1;
        exp_grant(1'b1);
        step();
        exp_grant(1'b1);
        step();
        M0_req = 0;
        exp_grant(1'b1);
        step();
        M0_req = 1;
        exp_grant(1'b0);
        step();
        exp_grant(1'b0);
        step();
        M1_req = 0;
        exp_grant(1'b0);
        step();
        exp_grant(1'b1);

        // M0 write to S0 while M1 inputs churn.
        M0_wr = 1; M0_address = 8'h05; M0_dout = 32'hDEAD_BEEF;
        M1_req = 1; M1_wr = 0; M1_address = 8'h25; M1_dout = 32'h1234_5678;
        #1;
        exp_bus(1'b1, 1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF);
        step();
        M1_wr = 1; M1_address = 8'h80; M1_dout = 32'hCAFE_F00D;
        exp_grant(1'b1);
        exp_bus(1'b1, 1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF);
        expect_at(cyc, SIG_DIN, 32'h22);

        // Window boundaries seen from M0.
        step();
        M0_wr = 0; M0_address = 8'h1F;
        exp_bus(1'b1, 1'b0, 1'b0, 8'h1F, 32'hDEAD_BEEF);
        step();
        M0_address = 8'h20;
        exp_bus(1'b0, 1'b1, 1'b0, 8'h20, 32'hDEAD_BEEF);
        expect_at(cyc + 1, SIG_DIN, 32'h11);

        // Hand over to M1: M0 drops, M1 already requesting a read at 8'h21.
        step();
        M0_req = 0; M0_address = 8'h00; M0_dout = 32'h0;
        M1_wr = 0; M1_address = 8'h21; M1_dout = 32'h0;
        exp_grant(1'b1);
        exp_bus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        m1_read(8'h21, 1'b0, 1'b1, 32'h11);
        m1_read(8'h03, 1'b1, 1'b0, 32'h22);
        m1_read(8'h80, 1'b0, 1'b0, 32'h0);
        m1_read(8'h3F, 1'b0, 1'b1, 32'h11);
        m1_read(8'h40, 1'b0, 1'b0, 32'h0);

        // Read to 8'h20, then reset lands before its data is consumed.
        step();
        M1_address = 8'h20;
        exp_bus(1'b0, 1'b1, 1'b0, 8'h20, 32'h0);
        step();
        reset_n = 1'b0;
        exp_grant(1'b1);
        expect_at(cyc, SIG_DIN, 32'h0);
        step();
        reset_n = 1'b1;
        M1_req = 0;
        exp_grant(1'b1);
        expect_at(cyc, SIG_DIN, 32'h0);

        step();
        step();
        done = 1'b1;
    end

    initial begin
        for (int i = 0; i < 2000 && !done; i++) @(posedge clk);
        @(negedge clk);
        if (!done) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete within 2000 cycles");
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expectations never compared (required 0)", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
